udp_rx_parser: RTL and testbench
================================

# udp_rx_parser

Receive-side UDP header parser that sits directly upstream of the UDP payload processor. It consumes an 8-bit AXI-Stream carrying one IPv4 payload per packet, starting at the UDP header. It strips and captures the 8-byte UDP header, filters on destination port and length, and forwards only the payload bytes with a correct `tlast`. Rejected packets are discarded and counted.

## Interface
- `LOCAL_PORT`, 16'd5000, accepted UDP destination port.
- `MIN_LEN`, 16'd9, minimum accepted UDP length field (header plus at least 1 payload byte).
- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset).
- `ip_axis_tdata_in`  input  8  UDP datagram byte stream.
- `ip_axis_tvalid_in`  input  1  input byte valid.
- `ip_axis_tlast_in`  input  1  last byte of IPv4 payload (may include padding).
- `ip_axis_tready_out`  output  1  parser can accept a byte.
- `udp_axis_tdata_out`  output  8  payload byte.
- `udp_axis_tvalid_out`  output  1  payload byte valid.
- `udp_axis_tlast_out`  output  1  last payload byte.
- `udp_axis_tready_in`  input  1  downstream ready.
- `src_port_out`  output  16  captured source port; held until the next accepted header.
- `udp_len_out`  output  16  captured length field; held until the next accepted header.
- `hdr_valid_out`  output  1  one-cycle pulse when a header is accepted.
- `drop_cnt_out`  output  16  saturating count of dropped packets.

## Operation
- A beat is a cycle with input `tvalid` and `tready` both high. Only beats advance state.
- FSM states: `HDR`, `PAYLOAD`, `PAD`, `DROP`.
- **HDR**
  - `ip_axis_tready_out` = 1. A 3-bit `hdr_cnt` counts beats 0..7.
  - Captured bytes: 0–1 src port, 2–3 dst port, 4–5 length. Bytes 6–7 (checksum) are ignored. All fields are big-endian.
  - On beat 7 without `tlast`:
    - If dst == `LOCAL_PORT` and length ≥ `MIN_LEN`: load `pay_cnt` = length − 8, pulse `hdr_valid_out`, update `src_port_out` and `udp_len_out`, go to `PAYLOAD`.
    - Otherwise: increment `drop_cnt_out` and go to `DROP`.
  - A `tlast` beat in `HDR` (runt packet, including beat 7) increments `drop_cnt_out`, clears `hdr_cnt`, and stays in `HDR`.
- **PAYLOAD**
  - Pass-through: `udp_axis_tvalid_out` = `ip_axis_tvalid_in`; `ip_axis_tready_out` = `udp_axis_tready_in`; data is direct.
  - Each beat decrements 16-bit `pay_cnt`.
  - `udp_axis_tlast_out` = (`pay_cnt` == 1) OR `ip_axis_tlast_in`.
  - On the final payload beat:
    - If `pay_cnt` == 1 and input `tlast`: go to `HDR`.
    - If `pay_cnt` == 1 without input `tlast`: go to `PAD`.
    - If input `tlast` arrives with `pay_cnt` > 1 (truncated datagram): output `tlast` is still asserted, the packet is not counted as dropped, and the FSM goes to `HDR`.
- **PAD**: `ip_axis_tready_out` = 1, no output. Input bytes are discarded until the `tlast` beat, then go to `HDR`. This covers Ethernet padding.
- **DROP**: same as `PAD`. The packet is already counted on entry.
- `drop_cnt_out` saturates at 16'hFFFF.
- Outside `PAYLOAD`, `udp_axis_tvalid_out` and `udp_axis_tlast_out` are 0.

## Timing
- Reset (`reset` = 0 at a clock edge) values:
  - state `HDR`, `hdr_cnt` 0, `pay_cnt` 0.
  - `src_port_out` 0, `udp_len_out` 0, `hdr_valid_out` 0, `drop_cnt_out` 0.
  - `udp_axis_tvalid_out` 0, `udp_axis_tlast_out` 0.
  - `ip_axis_tready_out` 1 from the first cycle after release.
- Reset mid-packet abandons that packet; the remainder of it is parsed as a new header.
- Header decisions are registered: the state change and `hdr_valid_out` take effect in the cycle after beat 7.
- The first payload byte can therefore be accepted the cycle after beat 7, giving zero bubble cycles at full rate.
- Payload latency is 0 cycles (combinational pass-through). Backpressure from `udp_axis_tready_in` propagates combinationally to `ip_axis_tready_out` in `PAYLOAD` only.
- AXIS rule: while a byte is offered and not accepted, the output byte stays stable, provided the source holds its data per AXIS rules.
- A packet with length == 8 fails `MIN_LEN` and is dropped.

## Configuration
- `UDP_RX_PORT_FILTER_EN` defined: the destination-port comparison against `LOCAL_PORT` is compiled in, as described above.
- Not defined: the destination port is ignored. Every header with length ≥ `MIN_LEN` is accepted; only length and runt checks drop packets.

## Test plan
- Header src 0x1234, dst 5000, len 12, then payload AA BB CC DD with `tlast` on DD:
  - Output AA..DD with `tlast` on DD.
  - `hdr_valid_out` pulses once; `src_port_out` = 0x1234; `udp_len_out` = 12.
- Same packet with dst 5001 (filter enabled): no output beats, `drop_cnt_out` = 1, next valid packet passes. With the macro undefined, the packet passes.
- len 10, 2 payload bytes, then 4 pad bytes with `tlast` on the last pad byte:
  - Output `tlast` on payload byte 2.
  - Pad bytes are swallowed, `ip_axis_tready_out` stays 1, and the next header parses correctly.
- 5-byte runt with `tlast` on byte 4: no output, `drop_cnt_out` +1, FSM back in `HDR`.
- len 20 but input `tlast` after 3 payload bytes: 3 bytes out with `tlast` on the third, `drop_cnt_out` unchanged.
- Random `udp_axis_tready_in` toggling (50%) over a 64-byte payload: the byte sequence is identical to the input with no loss or duplication. Assert `reset` = 0 mid-payload: outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/udp_rx_parser.sv
// UDP receive header parser: strips the 8-byte UDP header, filters on length (and optionally
// destination port when UDP_RX_PORT_FILTER_EN is defined), and passes payload bytes through.
module udp_rx_parser #(
    parameter logic [15:0] LOCAL_PORT = 16'd5000,
    parameter logic [15:0] MIN_LEN    = 16'd9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ip_axis_tdata_in,
    input  logic        ip_axis_tvalid_in,
    input  logic        ip_axis_tlast_in,
    output logic        ip_axis_tready_out,
    output logic [7:0]  udp_axis_tdata_out,
    output logic        udp_axis_tvalid_out,
    output logic        udp_axis_tlast_out,
    input  logic        udp_axis_tready_in,
    output logic [15:0] src_port_out,
    output logic [15:0] udp_len_out,
    output logic        hdr_valid_out,
    output logic [15:0] drop_cnt_out
);

`ifdef UDP_RX_PORT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {HDR, PAYLOAD, PAD, DROP} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  hdr_cnt_reg, hdr_cnt_next;
    logic [15:0] pay_cnt_reg, pay_cnt_next;
    logic [15:0] src_port_reg, src_port_next;
    logic [15:0] udp_len_reg, udp_len_next;
    logic        hdr_valid_reg, hdr_valid_next;
    logic [15:0] drop_cnt_reg, drop_cnt_next;
    logic        drop_inc;
    logic        beat;
    logic        hdr_ok;
    logic [7:0]  hdr_byte [6];
    logic [15:0] hdr_src, hdr_dst, hdr_len;

    // Header bytes 0..5 each land in their own register; checksum bytes 6..7 are not kept.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_hdr_cap
            logic [7:0] cap_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    cap_reg <= '0;
                end else if (state_reg == HDR && beat && hdr_cnt_reg == 3'(gi)) begin
                    cap_reg <= ip_axis_tdata_in;
                end
            end
            assign hdr_byte[gi] = cap_reg;
        end
    endgenerate

    assign hdr_src = {hdr_byte[0], hdr_byte[1]};
    assign hdr_dst = {hdr_byte[2], hdr_byte[3]};
    assign hdr_len = {hdr_byte[4], hdr_byte[5]};
    assign hdr_ok  = (!FILTER_EN || hdr_dst == LOCAL_PORT) && (hdr_len >= MIN_LEN);

    // Payload is a combinational pass-through, so backpressure reaches the source directly.
    assign ip_axis_tready_out  = (state_reg == PAYLOAD) ? udp_axis_tready_in : 1'b1;
    assign beat                = ip_axis_tvalid_in && ip_axis_tready_out;
    assign udp_axis_tdata_out  = ip_axis_tdata_in;
    assign udp_axis_tvalid_out = (state_reg == PAYLOAD) && ip_axis_tvalid_in;
    assign udp_axis_tlast_out  = (state_reg == PAYLOAD) &&
                                 ((pay_cnt_reg == 16'd1) || ip_axis_tlast_in);

    assign src_port_out  = src_port_reg;
    assign udp_len_out   = udp_len_reg;
    assign hdr_valid_out = hdr_valid_reg;
    assign drop_cnt_out  = drop_cnt_reg;

    always_comb begin
        state_next     = state_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        pay_cnt_next   = pay_cnt_reg;
        src_port_next  = src_port_reg;
        udp_len_next   = udp_len_reg;
        hdr_valid_next = 1'b0;
        drop_inc       = 1'b0;

        case (state_reg)
            HDR: begin
                if (beat) begin
                    if (ip_axis_tlast_in) begin
                        // Runt: packet ended inside the header.
                        hdr_cnt_next = 3'd0;
                        drop_inc     = 1'b1;
                    end else if (hdr_cnt_reg == 3'd7) begin
                        hdr_cnt_next = 3'd0;
                        if (hdr_ok) begin
                            pay_cnt_next   = hdr_len - 16'd8;
                            hdr_valid_next = 1'b1;
                            src_port_next  = hdr_src;
                            udp_len_next   = hdr_len;
                            state_next     = PAYLOAD;
                        end else begin
                            drop_inc   = 1'b1;
                            state_next = DROP;
                        end
                    end else begin
                        hdr_cnt_next = hdr_cnt_reg + 3'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (beat) begin
                    pay_cnt_next = pay_cnt_reg - 16'd1;
                    if (ip_axis_tlast_in) begin
                        state_next = HDR;
                    end else if (pay_cnt_reg == 16'd1) begin
                        state_next = PAD;
                    end
                end
            end
            PAD, DROP: begin
                if (beat && ip_axis_tlast_in) begin
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase

        drop_cnt_next = (drop_inc && drop_cnt_reg != 16'hFFFF) ? drop_cnt_reg + 16'd1
                                                                : drop_cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= HDR;
            hdr_cnt_reg   <= '0;
            pay_cnt_reg   <= '0;
            src_port_reg  <= '0;
            udp_len_reg   <= '0;
            hdr_valid_reg <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            pay_cnt_reg   <= pay_cnt_next;
            src_port_reg  <= src_port_next;
            udp_len_reg   <= udp_len_next;
            hdr_valid_reg <= hdr_valid_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Scoreboard bench for udp_rx_parser: packet-level reference model feeds expectation queues
// that an independent output monitor drains.
module tb_udp_rx_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ip_axis_tdata_in = '0;
    logic        ip_axis_tvalid_in = 1'b0;
    logic        ip_axis_tlast_in = 1'b0;
    logic        ip_axis_tready_out;
    logic [7:0]  udp_axis_tdata_out;
    logic        udp_axis_tvalid_out;
    logic        udp_axis_tlast_out;
    logic        udp_axis_tready_in = 1'b1;
    logic [15:0] src_port_out;
    logic [15:0] udp_len_out;
    logic        hdr_valid_out;
    logic [15:0] drop_cnt_out;

    always #5 clk = ~clk;

`ifdef UDP_RX_PORT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    udp_rx_parser dut (
        .clk                 (clk),
        .reset               (reset),
        .ip_axis_tdata_in    (ip_axis_tdata_in),
        .ip_axis_tvalid_in   (ip_axis_tvalid_in),
        .ip_axis_tlast_in    (ip_axis_tlast_in),
        .ip_axis_tready_out  (ip_axis_tready_out),
        .udp_axis_tdata_out  (udp_axis_tdata_out),
        .udp_axis_tvalid_out (udp_axis_tvalid_out),
        .udp_axis_tlast_out  (udp_axis_tlast_out),
        .udp_axis_tready_in  (udp_axis_tready_in),
        .src_port_out        (src_port_out),
        .udp_len_out         (udp_len_out),
        .hdr_valid_out       (hdr_valid_out),
        .drop_cnt_out        (drop_cnt_out)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [8:0]  exp_pay_q [$];
    logic [31:0] exp_hdr_q [$];
    logic [7:0]  pkt_q [$];
    int          model_drop = 0;
    int          exp_npay = 0;
    int          pkt_num = 0;
    logic [8:0]  mon_pay;
    logic [31:0] mon_hdr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (pkt %0d): got 0x%0h, expected 0x%0h", name, pkt_num, act, exp);
        end
    endtask

    task automatic build_pkt(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len, input int total);
        logic [7:0] hdr [8];
        hdr[0] = src[15:8];
        hdr[1] = src[7:0];
        hdr[2] = dst[15:8];
        hdr[3] = dst[7:0];
        hdr[4] = len[15:8];
        hdr[5] = len[7:0];
        hdr[6] = 8'($urandom);
        hdr[7] = 8'($urandom);
        pkt_q.delete();
        for (int i = 0; i < total; i++) pkt_q.push_back(i < 8 ? hdr[i] : 8'($urandom));
    endtask

    // Packet-level reference: decide accept/drop and list the payload bytes that must appear.
    task automatic model_pkt();
        int total = pkt_q.size();
        logic [15:0] dst;
        logic [15:0] len;
        exp_npay = 0;
        if (total <= 8) begin
            model_drop++;
            return;
        end
        dst = {pkt_q[2], pkt_q[3]};
        len = {pkt_q[4], pkt_q[5]};
        if (len < 16'd9 || (FILTER_EN && dst != 16'd5000)) begin
            model_drop++;
            return;
        end
        exp_npay = int'(len) - 8;
        if (total - 8 < exp_npay) exp_npay = total - 8;
        exp_hdr_q.push_back({pkt_q[0], pkt_q[1], len});
        for (int i = 0; i < exp_npay; i++)
            exp_pay_q.push_back({pkt_q[8 + i], (i == exp_npay - 1)});
    endtask

    task automatic do_reset_check();
        @(posedge clk); #1;
        reset = 1'b0;
        ip_axis_tvalid_in = 1'b0;
        udp_axis_tready_in = 1'b1;
        @(posedge clk); #1;
        ip_axis_tvalid_in = 1'b1;
        ip_axis_tdata_in = 8'h5A;
        ip_axis_tlast_in = 1'b0;
        @(negedge clk);
        check("rst_udp_tvalid", udp_axis_tvalid_out, 0);
        check("rst_udp_tlast", udp_axis_tlast_out, 0);
        check("rst_hdr_valid", hdr_valid_out, 0);
        check("rst_src_port", src_port_out, 0);
        check("rst_udp_len", udp_len_out, 0);
        check("rst_drop_cnt", drop_cnt_out, 0);
        @(posedge clk); #1;
        ip_axis_tvalid_in = 1'b0;
        reset = 1'b1;
        exp_pay_q.delete();
        exp_hdr_q.delete();
        model_drop = 0;
        @(negedge clk);
        check("rst_release_tready", ip_axis_tready_out, 1);
    endtask

    task automatic send_packet(input bit rand_valid, input bit rand_ready, input int abort_at);
        int idx = 0;
        int cycles = 0;
        int total;
        bit pending = 1'b0;
        bit offer;
        bit region;
        total = pkt_q.size();
        pkt_num++;
        model_pkt();
        $display("pkt %0d: %0d bytes in, %0d payload bytes expected, abort at %0d",
                 pkt_num, total, exp_npay, abort_at);
        while (idx < total) begin
            @(posedge clk); #1;
            offer = pending ? 1'b1 : (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
            ip_axis_tvalid_in = offer;
            ip_axis_tdata_in = pkt_q[idx];
            ip_axis_tlast_in = (idx == total - 1);
            udp_axis_tready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            region = (idx >= 8) && (idx < 8 + exp_npay);
            check("ip_tready", ip_axis_tready_out, region ? udp_axis_tready_in : 1'b1);
            check("udp_tvalid", udp_axis_tvalid_out, region && offer);
            pending = offer && !ip_axis_tready_out;
            if (offer && ip_axis_tready_out) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                do_reset_check();
                return;
            end
            cycles++;
            if (cycles > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout (pkt %0d): got %0d bytes accepted, expected %0d", pkt_num, idx, total);
                break;
            end
        end
        @(posedge clk); #1;
        ip_axis_tvalid_in = 1'b0;
        ip_axis_tlast_in = 1'b0;
        udp_axis_tready_in = 1'b1;
        repeat (2) @(negedge clk);
        check("drop_cnt", drop_cnt_out, model_drop);
    endtask

    task automatic set_payload_abcd();
        pkt_q[8] = 8'hAA;
        pkt_q[9] = 8'hBB;
        pkt_q[10] = 8'hCC;
        pkt_q[11] = 8'hDD;
    endtask

    // Output monitor: every accepted output beat and header pulse is matched against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (udp_axis_tvalid_out && udp_axis_tready_in) begin
                if (exp_pay_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pay_extra (pkt %0d): got byte 0x%0h, expected no output", pkt_num, udp_axis_tdata_out);
                end else begin
                    mon_pay = exp_pay_q.pop_front();
                    check("pay_data", udp_axis_tdata_out, mon_pay[8:1]);
                    check("pay_last", udp_axis_tlast_out, mon_pay[0]);
                end
            end
            if (hdr_valid_out) begin
                if (exp_hdr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL hdr_extra (pkt %0d): got hdr_valid, expected none", pkt_num);
                end else begin
                    mon_hdr = exp_hdr_q.pop_front();
                    check("hdr_src_port", src_port_out, mon_hdr[31:16]);
                    check("hdr_udp_len", udp_len_out, mon_hdr[15:0]);
                end
            end
        end
    end

    initial begin
        int kind;
        int len;
        int total;
        logic [15:0] dst;

        do_reset_check();

        build_pkt(16'h1234, 16'd5000, 16'd12, 12);
        set_payload_abcd();
        send_packet(1'b0, 1'b0, -1);

        build_pkt(16'h1234, 16'd5001, 16'd12, 12);
        set_payload_abcd();
        send_packet(1'b0, 1'b0, -1);
        check("src_port_hold", src_port_out, 16'h1234);
        check("udp_len_hold", udp_len_out, 16'd12);

        build_pkt(16'h1234, 16'd5000, 16'd12, 12);
        set_payload_abcd();
        send_packet(1'b0, 1'b0, -1);

        build_pkt(16'h4321, 16'd5000, 16'd10, 14);
        send_packet(1'b0, 1'b0, -1);

        build_pkt(16'h1111, 16'd5000, 16'd12, 5);
        send_packet(1'b0, 1'b0, -1);

        build_pkt(16'h2222, 16'd5000, 16'd20, 11);
        send_packet(1'b0, 1'b0, -1);

        build_pkt(16'h3333, 16'd5000, 16'd8, 12);
        send_packet(1'b0, 1'b0, -1);

        build_pkt(16'h5555, 16'd5000, 16'd72, 72);
        send_packet(1'b1, 1'b1, -1);

        build_pkt(16'h6666, 16'd5000, 16'd72, 72);
        send_packet(1'b1, 1'b1, 38);

        build_pkt(16'h1234, 16'd5000, 16'd12, 12);
        set_payload_abcd();
        send_packet(1'b0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            dst = ($urandom_range(0, 1) != 0) ? 16'd5000 : 16'($urandom);
            case (kind)
                0: begin len = $urandom_range(9, 40); total = $urandom_range(1, 8); end
                1: begin len = $urandom_range(9, 40); total = len; end
                2: begin len = $urandom_range(9, 40); total = len + $urandom_range(1, 6); end
                3: begin len = $urandom_range(12, 40); total = $urandom_range(9, len - 1); end
                default: begin len = $urandom_range(0, 8); total = $urandom_range(9, 20); end
            endcase
            build_pkt(16'($urandom), dst, 16'(len), total);
            send_packet(1'b1, 1'b1, -1);
        end

        repeat (5) @(negedge clk);
        check("pay_queue_empty", exp_pay_q.size(), 0);
        check("hdr_queue_empty", exp_hdr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
